// File: rtl/dense16_neuron_mac.sv
// Serial fixed-point dense neuron: 16 multiply-accumulates against a static weight ROM,
// then bias-aligned rescale, saturation and optional ReLU, with valid/ready on both sides.
module dense16_neuron_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int RELU       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [16*DATA_WIDTH-1:0]     in_vec,
    input  logic [DATA_WIDTH-1:0]        w0,
    input  logic [DATA_WIDTH-1:0]        w1,
    input  logic [DATA_WIDTH-1:0]        w2,
    input  logic [DATA_WIDTH-1:0]        w3,
    input  logic [DATA_WIDTH-1:0]        w4,
    input  logic [DATA_WIDTH-1:0]        w5,
    input  logic [DATA_WIDTH-1:0]        w6,
    input  logic [DATA_WIDTH-1:0]        w7,
    input  logic [DATA_WIDTH-1:0]        w8,
    input  logic [DATA_WIDTH-1:0]        w9,
    input  logic [DATA_WIDTH-1:0]        w10,
    input  logic [DATA_WIDTH-1:0]        w11,
    input  logic [DATA_WIDTH-1:0]        w12,
    input  logic [DATA_WIDTH-1:0]        w13,
    input  logic [DATA_WIDTH-1:0]        w14,
    input  logic [DATA_WIDTH-1:0]        w15,
    input  logic [DATA_WIDTH-1:0]        bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         busy
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                   state_r;
    logic [3:0]                   idx_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic [DATA_WIDTH-1:0]        x_r [16];
    logic                         in_ready_r;
    logic                         busy_r;
    logic                         out_valid_r;
    logic [DATA_WIDTH-1:0]        out_data_r;

    logic [DATA_WIDTH-1:0]        w_sel_s;
    logic signed [PROD_WIDTH-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0]  prod_ext_s;
    logic signed [ACC_WIDTH-1:0]  bias_ext_s;
    logic signed [ACC_WIDTH-1:0]  shifted_s;
    logic [DATA_WIDTH-1:0]        result_s;

    // Weight ROM output for the element currently being accumulated
    always_comb begin
        w_sel_s = {DATA_WIDTH{1'b0}};
        case (idx_r)
            4'd0:    w_sel_s = w0;
            4'd1:    w_sel_s = w1;
            4'd2:    w_sel_s = w2;
            4'd3:    w_sel_s = w3;
            4'd4:    w_sel_s = w4;
            4'd5:    w_sel_s = w5;
            4'd6:    w_sel_s = w6;
            4'd7:    w_sel_s = w7;
            4'd8:    w_sel_s = w8;
            4'd9:    w_sel_s = w9;
            4'd10:   w_sel_s = w10;
            4'd11:   w_sel_s = w11;
            4'd12:   w_sel_s = w12;
            4'd13:   w_sel_s = w13;
            4'd14:   w_sel_s = w14;
            4'd15:   w_sel_s = w15;
            default: w_sel_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Full-precision product and operand alignment into accumulator width
    always_comb begin
        prod_s     = $signed(x_r[idx_r]) * $signed(w_sel_s);
        prod_ext_s = {{(ACC_WIDTH-PROD_WIDTH){prod_s[PROD_WIDTH-1]}}, prod_s};
        bias_ext_s = $signed({{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias}) <<< FRAC_BITS;
    end

    // Rescale by truncation toward -inf, then saturate and optionally rectify
    always_comb begin
        shifted_s = acc_r >>> FRAC_BITS;
        result_s  = shifted_s[DATA_WIDTH-1:0];
        if ((RELU != 0) && shifted_s[ACC_WIDTH-1]) begin
            result_s = {DATA_WIDTH{1'b0}};
        end else if (shifted_s > SAT_MAX) begin
            result_s = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted_s < SAT_MIN) begin
            result_s = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result_s = shifted_s[DATA_WIDTH-1:0];
        end
    end

    // Control FSM, datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 4'd0;
            acc_r       <= {ACC_WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            for (int k = 0; k < 16; k++) begin
                x_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        for (int k = 0; k < 16; k++) begin
                            x_r[k] <= in_vec[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        acc_r      <= bias_ext_s;
                        idx_r      <= 4'd0;
                        state_r    <= ST_MAC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_r + prod_ext_s;
                    idx_r <= idx_r + 4'd1;
                    if (idx_r == 4'd15) begin
                        state_r <= ST_FINAL;
                    end else begin
                        state_r <= ST_MAC;
                    end
                end
                ST_FINAL: begin
                    out_data_r  <= result_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= 4'd0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule
